// File: rtl/contador_m_ud_pkg.sv
// Shared definitions for the modulo-M up/down counter.
// Holds the default modulus/width, the direction and terminal-mode encodings,
// and the per-edge action type used by the next-state mux.
package contador_m_ud_pkg;

    localparam int unsigned DEF_M = 16;
    localparam int unsigned DEF_N = 4;

    // Terminal behaviour (sat input)
    localparam logic MODE_SAT  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;

    // Direction (up input)
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // What the counter does at the next edge when clr is low
    typedef enum logic [1:0] {
        ACT_HOLD,   // no change
        ACT_LOAD,   // clamped parallel load
        ACT_STEP,   // +1 / -1 away from the terminal
        ACT_TURN    // wrap from the terminal to the opposite end
    } act_e;

endpackage

// File: rtl/contador_m_ud_if.sv
// Control/status bundle of the modulo-M up/down counter.
// master: drives ld, D, ent, enp, up, sat; observes Q, rco, fim, meio, wrap.
// slave : the counter itself.
interface contador_m_ud_if
    import contador_m_ud_pkg::*;
#(
    parameter int unsigned N = DEF_N
);

    logic         ld;
    logic [N-1:0] D;
    logic         ent;
    logic         enp;
    logic         up;
    logic         sat;
    logic [N-1:0] Q;
    logic         rco;
    logic         fim;
    logic         meio;
    logic         wrap;

    modport master (
        output ld, D, ent, enp, up, sat,
        input  Q, rco, fim, meio, wrap
    );

    modport slave (
        input  ld, D, ent, enp, up, sat,
        output Q, rco, fim, meio, wrap
    );

endinterface

// File: rtl/contador_m_ud_tc.sv
// Combinational terminal/flag decoder for the modulo-M counter.
// Ports: q (count), up (direction), ent (enable T) ->
//        at_term (q at terminal for current direction), rco (ent && at_term),
//        fim (q == M-1), meio (q == M/2).
module contador_m_ud_tc
    import contador_m_ud_pkg::*;
#(
    parameter int unsigned M = DEF_M,
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0] q,
    input  logic         up,
    input  logic         ent,
    output logic         at_term,
    output logic         rco,
    output logic         fim,
    output logic         meio
);

    localparam logic [N-1:0] Q_MAX = N'(M - 1);
    localparam logic [N-1:0] Q_MID = N'(M / 2);

    // Terminal follows the live direction, so a reversal re-evaluates it at once
    assign at_term = (up == DIR_UP) ? (q == Q_MAX) : (q == '0);
    // Carry ignores enp and sat so chains behave like 74163 cascades
    assign rco     = ent & at_term;
    assign fim     = (q == Q_MAX);
    assign meio    = (q == Q_MID);

endmodule

// File: rtl/contador_m_ud.sv
// Parametrised synchronous modulo-M up/down counter with clamped load,
// wrap/saturate terminal mode, decoded flags and a registered wrap pulse.
// Ports: clock, clr (sync active-high, highest priority),
//        bus (slave modport): ld, D, ent, enp, up, sat in; Q, rco, fim, meio, wrap out.
// rco/fim/meio are combinational decodes of Q; Q and wrap are registered.
module contador_m_ud
    import contador_m_ud_pkg::*;
#(
    parameter int unsigned M = DEF_M,
    parameter int unsigned N = DEF_N
) (
    input  logic             clock,
    input  logic             clr,
    contador_m_ud_if.slave   bus
);

    localparam logic [N-1:0] Q_MAX = N'(M - 1);

    logic [N-1:0] q_r;
    logic [N-1:0] q_nxt;
    logic         wrap_r;
    logic         wrap_nxt;
    logic         at_term;
    logic         rco;
    logic         fim;
    logic         meio;
    act_e         act;

    contador_m_ud_tc #(
        .M (M),
        .N (N)
    ) u_tc (
        .q       (q_r),
        .up      (bus.up),
        .ent     (bus.ent),
        .at_term (at_term),
        .rco     (rco),
        .fim     (fim),
        .meio    (meio)
    );

    // Action select: load beats counting; saturating at the terminal is a hold
    always_comb begin
        act = ACT_HOLD;
        if (bus.ld) begin
            act = ACT_LOAD;
        end else if (bus.ent && bus.enp) begin
            if (!at_term) begin
                act = ACT_STEP;
            end else if (bus.sat == MODE_WRAP) begin
                act = ACT_TURN;
            end
        end
    end

    // Next-state mux; wrap pulse is only raised by a turn
    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        case (act)
            ACT_LOAD: q_nxt = (bus.D > Q_MAX) ? Q_MAX : bus.D;
            ACT_STEP: q_nxt = (bus.up == DIR_UP) ? q_r + N'(1) : q_r - N'(1);
            ACT_TURN: begin
                q_nxt    = (bus.up == DIR_UP) ? '0 : Q_MAX;
                wrap_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // State registers with synchronous clear
    always_ff @(posedge clock) begin
        if (clr) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.Q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.rco  = rco;
    assign bus.fim  = fim;
    assign bus.meio = meio;

endmodule

// File: tb/tb_contador_m_ud.sv
// Bench for contador_m_ud: M=10 main instance, M=16 instance, and a two-digit
// decimal cascade (lower rco -> upper ent). Reference model uses plain modular
// arithmetic over integers.
module tb_contador_m_ud;

    logic clock = 1'b0;
    logic clr10 = 1'b1;
    logic clr16 = 1'b1;
    logic clrc  = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state for the M=10 instance
    int mq = 0;
    bit mw = 1'b0;

    contador_m_ud_if #(.N(4)) bi ();
    contador_m_ud_if #(.N(4)) b16 ();
    contador_m_ud_if #(.N(4)) lc ();
    contador_m_ud_if #(.N(4)) hc ();

    contador_m_ud #(.M(10), .N(4)) dut   (.clock(clock), .clr(clr10), .bus(bi));
    contador_m_ud #(.M(16), .N(4)) dut16 (.clock(clock), .clr(clr16), .bus(b16));
    contador_m_ud #(.M(10), .N(4)) u_lo  (.clock(clock), .clr(clrc),  .bus(lc));
    contador_m_ud #(.M(10), .N(4)) u_hi  (.clock(clock), .clr(clrc),  .bus(hc));

    assign hc.ent = lc.rco;

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {Q, wrap, rco, fim, meio} for a count value q of a modulo-m counter
    function automatic logic [7:0] exp_vec(input int q, input bit w, input bit ent,
                                           input bit up, input int m);
        bit term;
        term = up ? (q == m - 1) : (q == 0);
        return {4'(q), w, ent && term, (q == m - 1), (q == m / 2)};
    endfunction

    // Advance one edge; the M=10 model follows the inputs seen at that edge
    task automatic tick();
        if (clr10) begin
            mq = 0;
            mw = 1'b0;
        end else if (bi.ld) begin
            mq = (int'(bi.D) > 9) ? 9 : int'(bi.D);
            mw = 1'b0;
        end else if (bi.ent && bi.enp) begin
            if (bi.up) begin
                if (mq == 9 && bi.sat) mw = 1'b0;
                else begin mw = (mq == 9); mq = (mq + 1) % 10; end
            end else begin
                if (mq == 0 && bi.sat) mw = 1'b0;
                else begin mw = (mq == 0); mq = (mq + 9) % 10; end
            end
        end else begin
            mw = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got, exp;
        clr10 = 1'b1; bi.ld = 1'b1; bi.D = 4'd6; bi.ent = 1'b1; bi.enp = 1'b1;
        bi.up = 1'b0; bi.sat = 1'b0;
        tick();
        tick();
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(0, 1'b0, 1'b1, 1'b0, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset: got %b exp %b", got, exp);
        end
        bi.up = 1'b1;
        #1;
        vectors++;
        if (bi.rco !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rco_up: got %b exp 0", bi.rco);
        end
        bi.ld = 1'b0;
    endtask

    task automatic test_count_up();
        int eq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        logic [7:0] got, exp;
        clr10 = 1'b1; bi.ld = 1'b0; bi.D = '0; bi.ent = 1'b1; bi.enp = 1'b1;
        bi.up = 1'b1; bi.sat = 1'b0;
        tick();
        clr10 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
            exp = exp_vec(eq[i], (i == 9), 1'b1, 1'b1, 10);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL count_up[%0d]: got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_count_down();
        int eq [3] = '{9, 8, 7};
        logic [7:0] got, exp;
        clr10 = 1'b1; bi.ld = 1'b0; bi.ent = 1'b1; bi.enp = 1'b1;
        bi.up = 1'b0; bi.sat = 1'b0;
        tick();
        clr10 = 1'b0;
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(0, 1'b0, 1'b1, 1'b0, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL down_start: got %b exp %b", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
            exp = exp_vec(eq[i], (i == 0), 1'b1, 1'b0, 10);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL count_down[%0d]: got %b exp %b", i, got, exp);
            end
        end
    endtask

    task automatic test_saturate();
        int eq [5] = '{8, 9, 9, 9, 9};
        logic [7:0] got, exp;
        bi.ld = 1'b1; bi.D = 4'd7; bi.ent = 1'b0; bi.enp = 1'b0; bi.up = 1'b1; bi.sat = 1'b1;
        tick();
        bi.ld = 1'b0;
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(7, 1'b0, 1'b0, 1'b1, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL sat_load: got %b exp %b", got, exp);
        end
        bi.ent = 1'b1; bi.enp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
            exp = exp_vec(eq[i], 1'b0, 1'b1, 1'b1, 10);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got %b exp %b", i, got, exp);
            end
        end
        bi.sat = 1'b0;
    endtask

    task automatic test_load_clamp();
        // {clr, D, counting enabled, expected Q}
        int tc [7][4] = '{'{0, 13, 0, 9}, '{0, 3, 1, 3}, '{1, 5, 1, 0}, '{0, 15, 1, 9},
                          '{0, 9, 1, 9}, '{0, 10, 0, 9}, '{0, 0, 1, 0}};
        logic [7:0] got, exp;
        bi.up = 1'b1; bi.sat = 1'b0; bi.enp = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clr10  = tc[i][0][0];
            bi.ld  = 1'b1;
            bi.D   = 4'(tc[i][1]);
            bi.ent = tc[i][2][0];
            tick();
            got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
            exp = exp_vec(tc[i][3], 1'b0, tc[i][2][0], 1'b1, 10);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL load_clamp[%0d]: got %b exp %b", i, got, exp);
            end
        end
        clr10 = 1'b0; bi.ld = 1'b0;
    endtask

    task automatic test_enable_gating();
        logic [7:0] got, exp;
        bi.ld = 1'b1; bi.D = 4'd9; bi.ent = 1'b0; bi.enp = 1'b0; bi.up = 1'b1; bi.sat = 1'b0;
        tick();
        bi.ld = 1'b0; bi.ent = 1'b1; bi.enp = 1'b0;
        tick();
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(9, 1'b0, 1'b1, 1'b1, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL gate_enp: got %b exp %b", got, exp);
        end
        bi.ent = 1'b0; bi.enp = 1'b1;
        tick();
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(9, 1'b0, 1'b0, 1'b1, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL gate_ent: got %b exp %b", got, exp);
        end
        // Reverse direction at the up-terminal: no longer terminal, no wrap
        bi.ent = 1'b1; bi.up = 1'b0;
        #1;
        vectors++;
        if (bi.rco !== 1'b0) begin
            miscompares++;
            $display("FAIL reverse_rco: got %b exp 0", bi.rco);
        end
        tick();
        got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
        exp = exp_vec(8, 1'b0, 1'b1, 1'b0, 10);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reverse_step: got %b exp %b", got, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got, exp;
        clr16 = 1'b1; b16.ld = 1'b0; b16.D = '0; b16.ent = 1'b1; b16.enp = 1'b1;
        b16.up = 1'b1; b16.sat = 1'b0;
        tick();
        clr16 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            got = {b16.Q, b16.wrap, b16.rco, b16.fim, b16.meio};
            exp = exp_vec(i % 16, (i == 16), 1'b1, 1'b1, 16);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL m16_count[%0d]: got %b exp %b", i, got, exp);
            end
        end
        for (int i = 0; i < 15; i++) tick();
        got = {b16.Q, b16.wrap, b16.rco, b16.fim, b16.meio};
        exp = exp_vec(15, 1'b0, 1'b1, 1'b1, 16);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL m16_at15: got %b exp %b", got, exp);
        end
        clr16 = 1'b1;
        tick();
        clr16 = 1'b0;
        got = {b16.Q, b16.wrap, b16.rco, b16.fim, b16.meio};
        exp = exp_vec(0, 1'b0, 1'b1, 1'b1, 16);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL mid_reset: got %b exp %b", got, exp);
        end
        tick();
        got = {b16.Q, b16.wrap, b16.rco, b16.fim, b16.meio};
        exp = exp_vec(1, 1'b0, 1'b1, 1'b1, 16);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL after_reset: got %b exp %b", got, exp);
        end
    endtask

    task automatic test_cascade();
        logic [7:0] got, exp;
        logic [1:0] gw, ew;
        clrc = 1'b1;
        lc.ld = 1'b0; lc.D = '0; lc.ent = 1'b1; lc.enp = 1'b1; lc.up = 1'b1; lc.sat = 1'b0;
        hc.ld = 1'b0; hc.D = '0; hc.enp = 1'b1; hc.up = 1'b1; hc.sat = 1'b0;
        tick();
        clrc = 1'b0;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) tick();
            got = {hc.Q, lc.Q};
            exp = {4'((k % 100) / 10), 4'(k % 10)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cascade[%0d]: got %h exp %h", k, got, exp);
            end
            gw = {hc.wrap, lc.wrap};
            ew = {(k > 0 && k % 100 == 0), (k > 0 && k % 10 == 0)};
            if (k % 10 == 0 || k % 10 == 1) begin
                vectors++;
                if (gw !== ew) begin
                    miscompares++;
                    $display("FAIL cascade_wrap[%0d]: got %b exp %b", k, gw, ew);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        bit up_s  = 1'b1;
        bit sat_s = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0)  up_s  = ~up_s;
            if ($urandom_range(0, 15) == 0) sat_s = ~sat_s;
            clr10  = ($urandom_range(0, 40) == 0);
            bi.ld  = ($urandom_range(0, 9) == 0);
            bi.D   = 4'($urandom_range(0, 15));
            bi.ent = ($urandom_range(0, 7) != 0);
            bi.enp = ($urandom_range(0, 7) != 0);
            bi.up  = up_s;
            bi.sat = sat_s;
            #1;
            vectors++;
            if (bi.rco !== (bi.ent && (bi.up ? (mq == 9) : (mq == 0)))) begin
                miscompares++;
                $display("FAIL rand_rco[%0d]: got %b q=%0d ent=%b up=%b", i, bi.rco, mq, bi.ent, bi.up);
            end
            tick();
            got = {bi.Q, bi.wrap, bi.rco, bi.fim, bi.meio};
            exp = exp_vec(mq, mw, bi.ent, bi.up, 10);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rand[%0d]: got %b exp %b", i, got, exp);
            end
        end
        clr10 = 1'b0;
    endtask

    initial begin
        bi.ld = 1'b0; bi.D = '0; bi.ent = 1'b0; bi.enp = 1'b0; bi.up = 1'b1; bi.sat = 1'b0;
        b16.ld = 1'b0; b16.D = '0; b16.ent = 1'b0; b16.enp = 1'b0; b16.up = 1'b1; b16.sat = 1'b0;
        lc.ld = 1'b0; lc.D = '0; lc.ent = 1'b0; lc.enp = 1'b0; lc.up = 1'b1; lc.sat = 1'b0;
        hc.ld = 1'b0; hc.D = '0; hc.enp = 1'b0; hc.up = 1'b1; hc.sat = 1'b0;
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clamp();
        test_enable_gating();
        test_mid_reset();
        test_cascade();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
